// File: rtl/sgmii_pkg.sv
// Shared constants for the SGMII link manager: PCS register map, field positions,
// sequencer state encoding, fault codes and speed codes.
package sgmii_pkg;

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_ADV    = 8'h04;
    localparam logic [7:0] ADDR_LP     = 8'h05;
    localparam logic [7:0] ADDR_LTIMER = 8'h12;

    localparam int CTRL_MII_RESET  = 15;
    localparam int CTRL_AN_ENABLE  = 12;
    localparam int CTRL_POWER_DOWN = 11;
    localparam int CTRL_RESTART_AN = 9;

    // AN enable + restart, with reset and power-down explicitly held low
    localparam logic [31:0] CTRL_AN_RESTART =
        ((32'd1 << CTRL_AN_ENABLE) | (32'd1 << CTRL_RESTART_AN)) &
        ~((32'd1 << CTRL_MII_RESET) | (32'd1 << CTRL_POWER_DOWN));

    localparam int LP_LINK      = 15;
    localparam int LP_DUPLEX    = 12;
    localparam int LP_SPEED_LSB = 10;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_WR_TIMER = 4'd1;
    localparam logic [3:0] ST_WR_ADV   = 4'd2;
    localparam logic [3:0] ST_WR_CTRL  = 4'd3;
    localparam logic [3:0] ST_WAIT_AN  = 4'd4;
    localparam logic [3:0] ST_RD_LP    = 4'd5;
    localparam logic [3:0] ST_UP       = 4'd6;
    localparam logic [3:0] ST_FAULT    = 4'd7;

    typedef enum logic [1:0] {
        FAULT_NONE    = 2'b00,
        FAULT_ACK     = 2'b01,
        FAULT_RETRY   = 2'b10,
        FAULT_LP_LINK = 2'b11
    } fault_e;

    localparam logic [1:0] SPEED_10   = 2'b00;
    localparam logic [1:0] SPEED_100  = 2'b01;
    localparam logic [1:0] SPEED_1000 = 2'b10;

    // The reserved speed code 2'b11 is reported as gigabit
    function automatic logic [1:0] decodeSpeed(input logic [1:0] field);
        return (field == 2'b11) ? SPEED_1000 : field;
    endfunction

endpackage

// File: rtl/sgmii_wb_master.sv
// Single-transaction Wishbone master: one request, held until ack or ack timeout.
module sgmii_wb_master #(
    parameter logic [7:0] ACK_TIMEOUT = 8'd16
) (
    input  logic        clkSys,
    input  logic        rstN,
    input  logic        abort,
    input  logic        req,
    input  logic        we,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic        timeout,
    output logic        cyc,
    output logic        stb,
    output logic        wen,
    output logic [7:0]  busAddr,
    output logic [31:0] busWrData,
    input  logic [31:0] busRdData,
    input  logic        ack
);

    logic        active;
    logic        weQ;
    logic [7:0]  addrQ;
    logic [31:0] dataQ;
    logic [7:0]  ackCnt;

    always_ff @(posedge clkSys or negedge rstN) begin
        if (!rstN) begin
            active <= 1'b0;
            weQ    <= 1'b0;
            addrQ  <= '0;
            dataQ  <= '0;
            ackCnt <= '0;
        end else if (abort) begin
            active <= 1'b0;
        end else if (active) begin
            if (ack || ackCnt == 8'd0)
                active <= 1'b0;
            else
                ackCnt <= ackCnt - 8'd1;
        end else if (req) begin
            active <= 1'b1;
            weQ    <= we;
            addrQ  <= addr;
            dataQ  <= wdata;
            ackCnt <= ACK_TIMEOUT - 8'd1;
        end
    end

    // Gating by active lets an async reset clear the bus without waiting for a clock
    assign cyc       = active;
    assign stb       = active;
    assign wen       = active & weQ;
    assign busAddr   = active ? addrQ : '0;
    assign busWrData = active ? dataQ : '0;

    assign done    = active & ack;
    assign timeout = active & ~ack & (ackCnt == 8'd0);
    assign rdata   = busRdData;

endmodule

// File: rtl/sgmii_link_manager.sv
// SGMII bring-up sequencer: programs the PCS, runs auto-negotiation, decodes the
// partner ability word and supervises the link with retry and fault reporting.
//
// state     | meaning
// IDLE      | waiting for i_Enable
// WR_*      | programming link timer, advertised ability, control (AN restart)
// WAIT_AN   | AN restarted, timing completion
// RD_LP     | reading partner ability word
// UP        | link supervised, loss debounce running
// FAULT     | sticky until i_Enable drops
module sgmii_link_manager
    import sgmii_pkg::*;
#(
    parameter logic [20:0] LINK_TIMER    = 21'd200000,
    parameter logic [23:0] AN_TIMEOUT    = 24'd1250000,
    parameter logic [7:0]  ACK_TIMEOUT   = 8'd16,
    parameter logic [7:0]  LOSS_DEBOUNCE = 8'd8,
    parameter int          MAX_RETRY     = 3,
    parameter logic [15:0] ADV_ABILITY   = 16'h0001
) (
    input  logic        i_Clk,
    input  logic        i_ARst_L,
    input  logic        i_Enable,
    input  logic        i_Linkup,
    input  logic        i_ANDone,
    output logic        o_Cyc,
    output logic        o_Stb,
    output logic        o_WEn,
    output logic [7:0]  o8_Addr,
    output logic [31:0] o32_WrData,
    input  logic [31:0] i32_RdData,
    input  logic        i_Ack,
    output logic        o_LinkReady,
    output logic [1:0]  o2_Speed,
    output logic        o_Duplex,
    output logic        o_Fault,
    output logic [1:0]  o2_FaultCode,
    output logic [3:0]  o4_State
);

    localparam logic [3:0] MAX_RETRY_C = 4'(MAX_RETRY);

    logic [3:0]  state;
    logic        reqSent;
    logic        busStart, busWe, busDone, busTimeout;
    logic [7:0]  busAddr;
    logic [31:0] busWrData, busRdData;
    logic [23:0] anCnt;
    logic [7:0]  lossCnt;
    logic [3:0]  retryCnt, retryNext;
    logic        attemptFailed;
    fault_e      failCode, faultCode;
    logic        linkReady, duplex, fault;
    logic [1:0]  speed;
    logic        unusedRdBits;

    always_comb begin
        busWe     = 1'b1;
        busAddr   = ADDR_LTIMER;
        busWrData = '0;
        case (state)
            ST_WR_TIMER: busWrData = {11'd0, LINK_TIMER};
            ST_WR_ADV: begin
                busAddr   = ADDR_ADV;
                busWrData = {16'd0, ADV_ABILITY};
            end
            ST_WR_CTRL: begin
                busAddr   = ADDR_CTRL;
                busWrData = CTRL_AN_RESTART;
            end
            ST_RD_LP: begin
                busWe   = 1'b0;
                busAddr = ADDR_LP;
            end
            default: ;
        endcase
    end

    assign busStart  = i_Enable && !reqSent &&
                       (state inside {ST_WR_TIMER, ST_WR_ADV, ST_WR_CTRL, ST_RD_LP});
    assign retryNext = retryCnt + 4'd1;

    // AN timeout and a partner word without the link bit share one retry budget
    always_comb begin
        failCode      = FAULT_RETRY;
        attemptFailed = 1'b0;
        if (state == ST_WAIT_AN)
            attemptFailed = !(i_ANDone && i_Linkup) && (anCnt == 24'd1);
        else if (state == ST_RD_LP) begin
            failCode      = FAULT_LP_LINK;
            attemptFailed = busDone && !busRdData[LP_LINK];
        end
    end

    always_ff @(posedge i_Clk or negedge i_ARst_L) begin
        if (!i_ARst_L) begin
            state     <= ST_IDLE;
            reqSent   <= 1'b0;
            anCnt     <= '0;
            lossCnt   <= '0;
            retryCnt  <= '0;
            linkReady <= 1'b0;
            speed     <= SPEED_1000;
            duplex    <= 1'b1;
            fault     <= 1'b0;
            faultCode <= FAULT_NONE;
        end else if (!i_Enable) begin
            state     <= ST_IDLE;
            reqSent   <= 1'b0;
            anCnt     <= '0;
            lossCnt   <= '0;
            retryCnt  <= '0;
            linkReady <= 1'b0;
            fault     <= 1'b0;
            faultCode <= FAULT_NONE;
        end else begin
            if (busStart)
                reqSent <= 1'b1;
            if (busDone || busTimeout)
                reqSent <= 1'b0;
            case (state)
                ST_IDLE: begin
                    state    <= ST_WR_TIMER;
                    retryCnt <= '0;
                end
                ST_WR_TIMER: if (busDone) state <= ST_WR_ADV;
                ST_WR_ADV:   if (busDone) state <= ST_WR_CTRL;
                ST_WR_CTRL: if (busDone) begin
                    state <= ST_WAIT_AN;
                    anCnt <= AN_TIMEOUT;
                end
                ST_WAIT_AN: begin
                    if (i_ANDone && i_Linkup)
                        state <= ST_RD_LP;
                    else
                        anCnt <= anCnt - 24'd1;
                end
                ST_RD_LP: if (busDone && busRdData[LP_LINK]) begin
                    speed     <= decodeSpeed(busRdData[LP_SPEED_LSB +: 2]);
                    duplex    <= busRdData[LP_DUPLEX];
                    linkReady <= 1'b1;
                    retryCnt  <= '0;
                    lossCnt   <= LOSS_DEBOUNCE;
                    state     <= ST_UP;
                end
                ST_UP: begin
                    if (i_Linkup)
                        lossCnt <= LOSS_DEBOUNCE;
                    else if (lossCnt == 8'd1) begin
                        linkReady <= 1'b0;
                        state     <= ST_WR_CTRL;
                    end else
                        lossCnt <= lossCnt - 8'd1;
                end
                default: ;
            endcase
            if (busTimeout) begin
                state     <= ST_FAULT;
                fault     <= 1'b1;
                faultCode <= FAULT_ACK;
            end
            if (attemptFailed) begin
                retryCnt <= retryNext;
                if (retryNext < MAX_RETRY_C)
                    state <= ST_WR_CTRL;
                else begin
                    state     <= ST_FAULT;
                    fault     <= 1'b1;
                    faultCode <= failCode;
                end
            end
        end
    end

    sgmii_wb_master #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_wbMaster (
        .clkSys    (i_Clk),
        .rstN      (i_ARst_L),
        .abort     (!i_Enable),
        .req       (busStart),
        .we        (busWe),
        .addr      (busAddr),
        .wdata     (busWrData),
        .done      (busDone),
        .rdata     (busRdData),
        .timeout   (busTimeout),
        .cyc       (o_Cyc),
        .stb       (o_Stb),
        .wen       (o_WEn),
        .busAddr   (o8_Addr),
        .busWrData (o32_WrData),
        .busRdData (i32_RdData),
        .ack       (i_Ack)
    );

    assign unusedRdBits = ^{busRdData[31:16], busRdData[14:13], busRdData[9:0]};

    assign o_LinkReady  = linkReady;
    assign o2_Speed     = speed;
    assign o_Duplex     = duplex;
    assign o_Fault      = fault;
    assign o2_FaultCode = faultCode;
    assign o4_State     = state;

endmodule

// File: tb/tb_sgmii_link_manager.sv
// Directed and randomized bench for sgmii_link_manager with a Wishbone slave model
// and a reference model of the expected transaction list and partner decode.
module tb_sgmii_link_manager;
    import sgmii_pkg::*;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] data;
    } txn_t;

    localparam int MAX_RETRY = 3;

    logic        clk = 1'b0;
    logic        rstN, enable, linkup, anDone, ack = 1'b0;
    logic [31:0] rdData;
    logic        cyc, stb, wen, linkReady, duplex, fault;
    logic [7:0]  addr;
    logic [31:0] wrData;
    logic [1:0]  speed, faultCode;
    logic [3:0]  state;

    int    nChecks = 0, nErrors = 0;
    int    fixedLat = -1;
    bit    slaveMute = 1'b0;
    txn_t  log[$];
    int    logBase = 0;

    always #4 clk = ~clk;

    sgmii_link_manager #(
        .AN_TIMEOUT    (24'd100),
        .ACK_TIMEOUT   (8'd16),
        .LOSS_DEBOUNCE (8'd8),
        .MAX_RETRY     (MAX_RETRY)
    ) dut (
        .i_Clk        (clk),
        .i_ARst_L     (rstN),
        .i_Enable     (enable),
        .i_Linkup     (linkup),
        .i_ANDone     (anDone),
        .o_Cyc        (cyc),
        .o_Stb        (stb),
        .o_WEn        (wen),
        .o8_Addr      (addr),
        .o32_WrData   (wrData),
        .i32_RdData   (rdData),
        .i_Ack        (ack),
        .o_LinkReady  (linkReady),
        .o2_Speed     (speed),
        .o_Duplex     (duplex),
        .o_Fault      (fault),
        .o2_FaultCode (faultCode),
        .o4_State     (state)
    );

    // Slave: acks after a per-transaction latency and logs completed transactions
    int waitCnt = 0, curLat = 0;
    bit inTxn = 1'b0;
    always @(negedge clk) begin
        if (ack)
            ack = 1'b0;
        else if (cyc && stb && !slaveMute) begin
            if (!inTxn) begin
                inTxn   = 1'b1;
                waitCnt = 0;
                curLat  = (fixedLat >= 0) ? fixedLat : int'($urandom_range(0, 3));
            end
            if (waitCnt >= curLat) begin
                ack = 1'b1;
                log.push_back('{we: wen, addr: addr, data: wrData});
                inTxn = 1'b0;
            end else
                waitCnt++;
        end else
            inTxn = 1'b0;
    end

    function automatic logic [1:0] refSpeed(input logic [31:0] lp);
        int s;
        s = int'(lp[11:10]);
        return (s == 3) ? 2'd2 : 2'(s);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic compareLog(input string tag, input int attempts, input bit withReads);
        txn_t exp[$];
        int   got;
        exp.push_back('{we: 1'b1, addr: 8'h12, data: 32'd200000});
        exp.push_back('{we: 1'b1, addr: 8'h04, data: 32'h0000_0001});
        for (int a = 0; a < attempts; a++) begin
            exp.push_back('{we: 1'b1, addr: 8'h00, data: 32'h0000_1200});
            if (withReads) exp.push_back('{we: 1'b0, addr: 8'h05, data: 32'h0});
        end
        got = log.size() - logBase;
        check({tag, "_txn_count"}, 32'(got), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got; i++) begin
            check($sformatf("%s_txn%0d_addr", tag, i), 32'(log[logBase+i].addr), 32'(exp[i].addr));
            check($sformatf("%s_txn%0d_we", tag, i), 32'(log[logBase+i].we), 32'(exp[i].we));
            if (exp[i].we)
                check($sformatf("%s_txn%0d_data", tag, i), log[logBase+i].data, exp[i].data);
        end
    endtask

    task automatic bringUp(input string tag, input logic [31:0] lp);
        int n;
        logBase = log.size();
        rdData  = lp;
        anDone  = 1'b0;
        linkup  = 1'b0;
        enable  = 1'b1;
        n = 0;
        while (log.size() - logBase < 3 && n < 400) begin @(negedge clk); n++; end
        check({tag, "_cfg_written"}, 32'(log.size() - logBase >= 3), 32'd1);
        repeat ($urandom_range(0, 20)) @(negedge clk);
        anDone = 1'b1;
        linkup = 1'b1;
        n = 0;
        while (!linkReady && !fault && n < 600) begin @(negedge clk); n++; end
        if (lp[15]) begin
            check({tag, "_ready"}, 32'(linkReady), 32'd1);
            check({tag, "_speed"}, 32'(speed), 32'(refSpeed(lp)));
            check({tag, "_duplex"}, 32'(duplex), 32'(lp[12]));
            check({tag, "_state_up"}, 32'(state), 32'(ST_UP));
            compareLog(tag, 1, 1'b1);
        end else begin
            check({tag, "_fault"}, 32'(fault), 32'd1);
            check({tag, "_fault_code"}, 32'(faultCode), 32'd3);
            check({tag, "_ready_low"}, 32'(linkReady), 32'd0);
            compareLog(tag, MAX_RETRY, 1'b1);
        end
    endtask

    task automatic shutDown(input string tag);
        int sz;
        enable = 1'b0;
        @(negedge clk);
        check({tag, "_off_state"}, 32'(state), 32'(ST_IDLE));
        check({tag, "_off_cyc"}, 32'(cyc), 32'd0);
        check({tag, "_off_ready"}, 32'(linkReady), 32'd0);
        check({tag, "_off_fault"}, 32'({fault, faultCode}), 32'd0);
        sz = log.size();
        repeat (10) @(negedge clk);
        check({tag, "_off_no_txn"}, 32'(log.size()), 32'(sz));
    endtask

    initial begin
        int n, cnt, sz;
        logic [31:0] lp;
        rstN = 1'b0; enable = 1'b0; linkup = 1'b0; anDone = 1'b0; rdData = '0;
        repeat (3) @(negedge clk);
        check("rst_cyc", 32'({cyc, stb, wen}), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_wdata", wrData, 32'd0);
        check("rst_ready", 32'(linkReady), 32'd0);
        check("rst_speed", 32'(speed), 32'd2);
        check("rst_duplex", 32'(duplex), 32'd1);
        check("rst_fault", 32'({fault, faultCode}), 32'd0);
        check("rst_state", 32'(state), 32'(ST_IDLE));
        rstN = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_hold", 32'(state), 32'(ST_IDLE));

        fixedLat = 2;
        bringUp("nominal", 32'h0000_9800);
        shutDown("nominal");
        fixedLat = -1;
        bringUp("p100_half", 32'h0000_8400);
        shutDown("p100_half");
        fixedLat = 15;
        bringUp("ack_at_limit", 32'h0000_D400);
        shutDown("ack_at_limit");
        fixedLat = -1;
        bringUp("reserved_speed", 32'h0000_8C00);
        shutDown("reserved_speed");
        bringUp("lp_nolink", 32'h0000_1400);
        shutDown("lp_nolink");

        // AN never completes
        logBase = log.size(); anDone = 1'b0; linkup = 1'b1; enable = 1'b1;
        n = 0;
        while (!fault && n < 2000) begin @(negedge clk); n++; end
        check("an_to_fault", 32'(fault), 32'd1);
        check("an_to_code", 32'(faultCode), 32'd2);
        check("an_to_ready", 32'(linkReady), 32'd0);
        compareLog("an_to", MAX_RETRY, 1'b0);
        sz = log.size();
        repeat (20) @(negedge clk);
        check("an_to_sticky", 32'({fault, state}), 32'({1'b1, ST_FAULT}));
        check("an_to_no_txn", 32'(log.size()), 32'(sz));
        shutDown("an_to");

        // slave never acks
        slaveMute = 1'b1; enable = 1'b1;
        n = 0;
        while (!cyc && n < 50) begin @(negedge clk); n++; end
        cnt = 0;
        while (cyc && cnt < 100) begin cnt++; @(negedge clk); end
        check("ackto_cycles", 32'(cnt), 32'd16);
        check("ackto_fault", 32'({fault, faultCode}), 32'({1'b1, 2'b01}));
        check("ackto_bus", 32'({cyc, stb, wen}), 32'd0);
        slaveMute = 1'b0;
        shutDown("ackto");

        // link-loss debounce
        bringUp("loss", 32'h0000_9800);
        sz = log.size();
        linkup = 1'b0;
        repeat (7) @(negedge clk);
        linkup = 1'b1;
        check("glitch7_ready", 32'(linkReady), 32'd1);
        repeat (3) @(negedge clk);
        check("glitch7_after", 32'({linkReady, state}), 32'({1'b1, ST_UP}));
        linkup = 1'b0;
        repeat (7) @(negedge clk);
        check("loss7_still_up", 32'(linkReady), 32'd1);
        @(negedge clk);
        check("loss8_ready_low", 32'(linkReady), 32'd0);
        check("loss_speed_hold", 32'({speed, duplex}), 32'({2'b10, 1'b1}));
        n = 0;
        while (log.size() == sz && n < 100) begin @(negedge clk); n++; end
        check("loss_new_txn", 32'(log.size()), 32'(sz + 1));
        if (log.size() > sz) begin
            check("loss_ctrl_addr", 32'(log[sz].addr), 32'h00);
            check("loss_ctrl_data", log[sz].data, 32'h0000_1200);
        end
        shutDown("loss");

        // abort with a transaction in flight
        fixedLat = 10; sz = log.size(); enable = 1'b1;
        n = 0;
        while (!cyc && n < 50) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        check("abort_stb_held", 32'(stb), 32'd1);
        enable = 1'b0;
        @(negedge clk);
        check("abort_bus_idle", 32'({cyc, stb, wen}), 32'd0);
        check("abort_state", 32'(state), 32'(ST_IDLE));
        cnt = 0;
        repeat (20) begin @(negedge clk); if (cyc) cnt++; end
        check("abort_no_bus", 32'(cnt), 32'd0);
        check("abort_no_txn", 32'(log.size()), 32'(sz));

        // async reset with a transaction in flight
        enable = 1'b1;
        n = 0;
        while (!cyc && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        #1 rstN = 1'b0;
        #1;
        check("arst_bus_drop", 32'({cyc, stb, addr}), 32'd0);
        check("arst_state", 32'(state), 32'(ST_IDLE));
        enable = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        fixedLat = -1;
        @(negedge clk);

        for (int it = 0; it < 8; it++) begin
            lp = $urandom();
            lp[15] = ($urandom_range(0, 3) != 0);
            bringUp($sformatf("rnd%0d", it), lp);
            shutDown($sformatf("rnd%0d", it));
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/sgmii_link_manager.md
Name: sgmii_link_manager

Overview:
- Bring-up and link-supervision sequencer for the SGMII PCS core.
- Acts as Wishbone master on the core's register bus and programs the link timer, local advertised ability and control register.
- Restarts auto-negotiation, waits for AN completion and decodes the partner's SGMII ability word into speed/duplex.
- Then supervises the link and re-runs AN on loss, with retry limit and fault reporting.

Parameters:
- LINK_TIMER, 21'd200000, value written to the link-timer register (1.6 ms at 125 MHz).
- AN_TIMEOUT, 24'd1250000, cycles allowed from AN restart to i_ANDone.
- ACK_TIMEOUT, 8'd16, cycles allowed for i_Ack per bus transaction.
- LOSS_DEBOUNCE, 8'd8, consecutive cycles of i_Linkup low that declare link loss.
- MAX_RETRY, 3, AN attempts before fault.
- ADV_ABILITY, 16'h0001, local advertised ability (SGMII MAC side: bit0 = 1).

Ports:
- i_Clk  in  1  system clock (125 MHz GMII clock domain)
- i_ARst_L  in  1  asynchronous active-low reset
- i_Enable  in  1  level; 1 = run bring-up, 0 = abort and idle
- i_Linkup  in  1  PCS sync status
- i_ANDone  in  1  AN complete
- o_Cyc  out  1  Wishbone cycle
- o_Stb  out  1  Wishbone strobe
- o_WEn  out  1  Wishbone write enable
- o8_Addr  out  8  register address
- o32_WrData  out  32  write data
- i32_RdData  in  32  read data
- i_Ack  in  1  Wishbone acknowledge
- o_LinkReady  out  1  link up and partner parameters valid
- o2_Speed  out  2  partner speed: 00 = 10M, 01 = 100M, 10 = 1000M
- o_Duplex  out  1  partner duplex, 1 = full
- o_Fault  out  1  sticky fault
- o2_FaultCode  out  2  01 = bus ack timeout, 10 = AN retries exhausted, 11 = partner link bit 0
- o4_State  out  4  current state encoding, for debug

Behaviour:
- Reset values:
  - all bus outputs 0, o_LinkReady 0, o2_Speed 2'b10, o_Duplex 1, o_Fault 0, o2_FaultCode 0.
  - State IDLE, retry counter 0.
- Register map (package constants):
  - CTRL = 8'h00: bit15 MII reset, bit12 AN enable, bit11 power-down, bit9 restart AN.
  - ADV = 8'h04.
  - LP = 8'h05: bit15 link, bit12 duplex, bits11:10 speed.
  - LTIMER = 8'h12.
- Bus transaction:
  - o_Cyc, o_Stb, o_WEn, address and data assert together and are held constant until i_Ack is sampled high.
  - All drop on the following cycle; read data is captured in the i_Ack cycle.
  - Minimum one idle cycle between transactions.
  - If ACK_TIMEOUT cycles elapse without i_Ack: drop the bus, set o_Fault, code 01, go FAULT.
- State sequence:
  - IDLE -> (i_Enable=1) WR_TIMER: write LINK_TIMER zero-extended to 32 bits at LTIMER.
  - WR_TIMER -> WR_ADV: write ADV_ABILITY at ADV.
  - WR_ADV -> WR_CTRL: write 32'h1200 at CTRL.
  - WR_CTRL -> WAIT_AN: AN counter cleared, increments each cycle.
  - WAIT_AN -> RD_LP when i_ANDone=1 and i_Linkup=1.
  - RD_LP -> UP: read LP and decode it.
    - If bit15=1: latch speed/duplex, assert o_LinkReady on the cycle after the ack, clear the retry counter.
    - If bit15=0: count it as a failed attempt (same retry path as an AN timeout; code 11 if retries are exhausted).
  - Speed field 2'b11 is reserved: treat as 1000M.
- AN timeout:
  - Counter reaches AN_TIMEOUT: increment retry counter.
  - If retry counter < MAX_RETRY, go back to WR_CTRL (rewrites restart).
  - Otherwise FAULT, code 10.
- UP state:
  - Debounce counter counts consecutive i_Linkup=0 cycles and resets on any 1.
  - Reaching LOSS_DEBOUNCE: o_LinkReady drops in the same cycle as the transition, go to WR_CTRL. Speed/duplex hold their last values.
- FAULT:
  - Sticky; bus idle, o_LinkReady 0.
  - Left only via i_Enable=0 (to IDLE, fault and code cleared).
- i_Enable=0 in any state:
  - Next cycle: bus deasserted (an in-flight transaction is abandoned), o_LinkReady 0, state IDLE, counters cleared.
- Simultaneity:
  - i_ANDone and AN timeout in the same cycle: completion wins.
  - i_Ack in the same cycle as the ack-timeout threshold: ack wins.
- Asynchronous reset mid-transaction: bus outputs drop immediately.

Decomposition:
- Shared package sgmii_pkg:
  - register addresses, control bit positions, LP field positions.
  - state encoding and fault codes.
  - speed codes, which match the existing core's speed encoding.
- One sub-module, sgmii_wb_master: single-transaction Wishbone master.
  - Inputs: req, we, addr, wdata.
  - Outputs: done, rdata, timeout; holds ACK_TIMEOUT.
- The sequencer FSM and its counters stay in the top module.

Test Plan:
- Nominal bring-up: i_Enable=1; slave acks after 2 cycles; raise i_ANDone/i_Linkup; LP read returns 32'h9800.
  - Expect writes 0x12=200000, 0x04=0x0001, 0x00=0x1200 in order.
  - Expect o_LinkReady=1, o2_Speed=10, o_Duplex=1.
- Partner 100M half: LP = 32'h8400 -> o2_Speed=01, o_Duplex=0, o_LinkReady=1.
- AN timeout (AN_TIMEOUT=100, MAX_RETRY=3), i_ANDone never asserted:
  - Expect exactly 3 CTRL writes of 0x1200.
  - Then o_Fault=1, code 10.
  - i_Enable low clears the fault.
- Ack timeout: slave never acks the first write -> o_Cyc drops after 16 cycles, o_Fault=1, code 01.
- Link loss debounce, in UP:
  - 7-cycle i_Linkup glitch -> no change.
  - 8-cycle low -> o_LinkReady=0 and a new CTRL write of 0x1200.
- Abort mid-transaction: i_Enable=0 while o_Stb is held -> bus idle on the next cycle, state IDLE, no further transactions.
